// File: rtl/uart_rx_param.sv
// uart_rx_param: mid-bit sampling UART receiver that feeds a first-word-fall-through FIFO.
// Define UART_RX_PARITY_EN to add a parity bit; ODD_PARITY then selects odd (1) or even (0).
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int ODD_PARITY   = 0
) (
    input  logic                        clock,
    input  logic                        clr,
    input  logic                        rx,
    input  logic                        rd_en,
    input  logic                        err_clr,
    output logic [DATA_BITS-1:0]        data,
    output logic                        valid,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        frame_err,
    output logic                        parity_err,
    output logic                        overrun
);

    // state    | meaning
    // IDLE     | line idle, waiting for a falling edge
    // START    | timing half a bit to confirm the start bit
    // DATA     | sampling data bits LSB-first at mid-bit
    // PARITY   | sampling the parity bit (only with UART_RX_PARITY_EN)
    // STOP     | sampling the stop bit, then push or flag
    // BREAK    | stop bit was low; wait for the line to return high
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);
    localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

    state_t                 state_q, state_d;
    logic [1:0]             sync_q, sync_d;
    logic [TW-1:0]          tmr_q, tmr_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_bad_q, par_bad_d;
    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0]   mem_d [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;

    logic rx_s;
    logic exp_par;
    logic stop_tick;
    logic push_req;
    logic push;
    logic pop;
    logic full;
    logic empty;

    always_comb begin
        sync_d = {sync_q[0], rx};
    end

    assign rx_s    = sync_q[1];
    assign exp_par = (^shift_q) ^ (ODD_PARITY != 0);

    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                if (tmr_q == T_HALF) state_d = rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (tmr_q == T_LAST && idx_q == I_LAST) begin
`ifdef UART_RX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
            S_PARITY: begin
                if (tmr_q == T_LAST) state_d = S_STOP;
            end
            S_STOP: begin
                if (tmr_q == T_LAST) state_d = rx_s ? S_IDLE : S_BREAK;
            end
            S_BREAK: begin
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bit timing and frame assembly; PARITY is unreachable without UART_RX_PARITY_EN.
    always_comb begin
        tmr_d     = '0;
        idx_d     = idx_q;
        shift_d   = shift_q;
        par_bad_d = par_bad_q;
        stop_tick = 1'b0;
        case (state_q)
            S_START: begin
                tmr_d = tmr_q + TW'(1);
                if (tmr_q == T_HALF) begin
                    tmr_d     = '0;
                    idx_d     = '0;
                    par_bad_d = 1'b0;
                end
            end
            S_DATA, S_PARITY, S_STOP: begin
                tmr_d = tmr_q + TW'(1);
                if (tmr_q == T_LAST) begin
                    tmr_d = '0;
                    if (state_q == S_DATA) begin
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        idx_d   = idx_q + IW'(1);
                    end
                    if (state_q == S_PARITY) par_bad_d = (rx_s != exp_par);
                    if (state_q == S_STOP)   stop_tick = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        full     = (count_q == C_FULL);
        empty    = (count_q == '0);
        pop      = rd_en & ~empty;
        push_req = stop_tick & rx_s & ~par_bad_q;
        // A pop in the same cycle frees the slot the push is about to use.
        push     = push_req & (~full | pop);

        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = shift_q;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        frame_err_d = (stop_tick & ~rx_s) | (frame_err_q & ~err_clr);
        overrun_d   = (push_req & full & ~pop) | (overrun_q & ~err_clr);
    end

    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            sync_q      <= 2'b11;
            tmr_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            par_bad_q   <= 1'b0;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            tmr_q       <= tmr_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            par_bad_q   <= par_bad_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_err_q, parity_err_d;

    always_comb begin
        parity_err_d = (stop_tick & par_bad_q) | (parity_err_q & ~err_clr);
    end

    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign data      = mem_q[rd_ptr_q];
    assign valid     = ~empty;
    assign count     = count_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param at 16 clocks per bit, 8 data bits, 4-entry FIFO.
// Frames are driven bit by bit; expected values are hand-computed per scenario.
module tb_uart_rx_param;

    localparam int CPB = 16;

    logic       clock   = 1'b0;
    logic       clr     = 1'b1;
    logic       rx      = 1'b1;
    logic       rd_en   = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic [2:0] count;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    uart_rx_param #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (8),
        .FIFO_DEPTH  (4),
        .ODD_PARITY  (0)
    ) dut (
        .clock     (clock),
        .clr       (clr),
        .rx        (rx),
        .rd_en     (rd_en),
        .err_clr   (err_clr),
        .data      (data),
        .valid     (valid),
        .count     (count),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .overrun   (overrun)
    );

    // Drives one frame. With pop_at_stop, rd_en is high on exactly the stop-sample edge
    // (start fall after posedge p0 -> FSM start at p0+3 -> stop sample at p0+3+8+(9+P)*16).
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_flip,
                              input logic pop_at_stop);
        logic [10:0] bits;
        logic        pbit;
        int          n;
        pbit = (^b) ^ par_flip;
`ifdef UART_RX_PARITY_EN
        bits = {stop, pbit, b, 1'b0};
        n = 11;
`else
        bits = {pbit, stop, b, 1'b0};
        n = 10;
`endif
        for (int i = 0; i < n; i++) begin
            rx = bits[i];
            if (i == n - 1 && pop_at_stop) begin
                repeat (10) @(posedge clock);
                #1 rd_en = 1'b1;
                @(posedge clock);
                #1 rd_en = 1'b0;
                repeat (5) @(posedge clock);
                #1;
            end else begin
                repeat (CPB) @(posedge clock);
                #1;
            end
        end
    endtask

    task automatic pop1();
        @(negedge clock);
        rd_en = 1'b1;
        @(negedge clock);
        rd_en = 1'b0;
    endtask

    task automatic pulse_err_clr();
        @(negedge clock);
        err_clr = 1'b1;
        @(negedge clock);
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data); end
        checks++;
        if ({valid, count} !== 4'b0) begin
            errors++; $display("FAIL reset_fifo got valid=%b count=%0d want 0/0", valid, count);
        end
        checks++;
        if ({frame_err, parity_err, overrun} !== 3'b0) begin
            errors++; $display("FAIL reset_flags got %b want 000", {frame_err, parity_err, overrun});
        end
        clr = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_single();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        checks++;
        if ({valid, count} !== {1'b1, 3'd1}) begin
            errors++; $display("FAIL single_fifo got valid=%b count=%0d want 1/1", valid, count);
        end
        checks++;
        if (data !== 8'hA5) begin errors++; $display("FAIL single_data got %h want a5", data); end
        checks++;
        if ({frame_err, parity_err, overrun} !== 3'b0) begin
            errors++; $display("FAIL single_flags got %b want 000", {frame_err, parity_err, overrun});
        end
        pop1();
        checks++;
        if ({valid, count} !== 4'b0) begin
            errors++; $display("FAIL single_pop got valid=%b count=%0d want 0/0", valid, count);
        end
    endtask

    task automatic test_glitch();
        @(negedge clock);
        rx = 1'b0;
        repeat (4) @(negedge clock);
        rx = 1'b1;
        repeat (30) @(negedge clock);
        checks++;
        if ({valid, count} !== 4'b0) begin
            errors++; $display("FAIL glitch_fifo got valid=%b count=%0d want 0/0", valid, count);
        end
        checks++;
        if ({frame_err, parity_err, overrun} !== 3'b0) begin
            errors++; $display("FAIL glitch_flags got %b want 000", {frame_err, parity_err, overrun});
        end
        // rd_en on the push edge with an empty FIFO must be ignored
        send_frame(8'h5A, 1'b1, 1'b0, 1'b1);
        @(negedge clock);
        checks++;
        if ({valid, count, data} !== {1'b1, 3'd1, 8'h5A}) begin
            errors++; $display("FAIL glitch_next got valid=%b count=%0d data=%h want 1/1/5a",
                               valid, count, data);
        end
        pop1();
    endtask

    task automatic test_framing();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (40) @(negedge clock);
        checks++;
        if (frame_err !== 1'b1) begin errors++; $display("FAIL frame_set got %b want 1", frame_err); end
        checks++;
        if ({valid, count} !== 4'b0) begin
            errors++; $display("FAIL frame_drop got valid=%b count=%0d want 0/0", valid, count);
        end
        checks++;
        if (parity_err !== 1'b0) begin errors++; $display("FAIL frame_par got %b want 0", parity_err); end
        rx = 1'b1;
        repeat (20) @(negedge clock);
        checks++;
        if (count !== 3'd0) begin errors++; $display("FAIL frame_retrig got count=%0d want 0", count); end
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        checks++;
        if ({count, data} !== {3'd1, 8'h11}) begin
            errors++; $display("FAIL frame_next got count=%0d data=%h want 1/11", count, data);
        end
        checks++;
        if (frame_err !== 1'b1) begin errors++; $display("FAIL frame_sticky got %b want 1", frame_err); end
        pulse_err_clr();
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("FAIL frame_clr got %b want 0", frame_err); end
        pop1();
    endtask

    task automatic test_back_to_back();
        for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        checks++;
        if ({valid, count, overrun} !== {1'b1, 3'd4, 1'b1}) begin
            errors++; $display("FAIL ovr_full got valid=%b count=%0d overrun=%b want 1/4/1",
                               valid, count, overrun);
        end
        for (int b = 1; b <= 4; b++) begin
            checks++;
            if (data !== 8'(b)) begin errors++; $display("FAIL ovr_order got %h want %0h", data, b); end
            pop1();
        end
        checks++;
        if (count !== 3'd0) begin errors++; $display("FAIL ovr_drain got count=%0d want 0", count); end
        pulse_err_clr();
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr got %b want 0", overrun); end

        for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1, 1'b0, (b == 5));
        @(negedge clock);
        checks++;
        if ({count, overrun} !== {3'd4, 1'b0}) begin
            errors++; $display("FAIL pushpop_full got count=%0d overrun=%b want 4/0", count, overrun);
        end
        for (int b = 2; b <= 5; b++) begin
            checks++;
            if (data !== 8'(b)) begin errors++; $display("FAIL pushpop_order got %h want %0h", data, b); end
            pop1();
        end
    endtask

    task automatic test_parity();
`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        checks++;
        if ({count, data, parity_err} !== {3'd1, 8'h07, 1'b0}) begin
            errors++; $display("FAIL par_good got count=%0d data=%h perr=%b want 1/07/0",
                               count, data, parity_err);
        end
        pop1();
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        @(negedge clock);
        checks++;
        if ({count, parity_err, frame_err} !== {3'd0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL par_bad got count=%0d perr=%b ferr=%b want 0/1/0",
                               count, parity_err, frame_err);
        end
        pulse_err_clr();
`else
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        checks++;
        if ({count, data, parity_err} !== {3'd1, 8'h07, 1'b0}) begin
            errors++; $display("FAIL par_off got count=%0d data=%h perr=%b want 1/07/0",
                               count, data, parity_err);
        end
        pop1();
`endif
    endtask

    task automatic test_clr_mid();
        logic [7:0] b;
        send_frame(8'h99, 1'b1, 1'b0, 1'b0);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        rx = 1'b1;
        repeat (5) @(negedge clock);
        checks++;
        if ({count, frame_err} !== {3'd1, 1'b1}) begin
            errors++; $display("FAIL clr_pre got count=%0d ferr=%b want 1/1", count, frame_err);
        end
        b = 8'hC3;
        @(posedge clock);
        #1 rx = 1'b0;
        repeat (CPB) @(posedge clock);
        for (int i = 0; i < 3; i++) begin
            #1 rx = b[i];
            repeat (CPB) @(posedge clock);
        end
        #1 rx = b[3];
        repeat (CPB / 2) @(posedge clock);
        #1 clr = 1'b1;
        rx = 1'b1;
        @(negedge clock);
        checks++;
        if ({data, valid, count} !== 12'b0) begin
            errors++; $display("FAIL clr_fifo got data=%h valid=%b count=%0d want 00/0/0",
                               data, valid, count);
        end
        checks++;
        if ({frame_err, parity_err, overrun} !== 3'b0) begin
            errors++; $display("FAIL clr_flags got %b want 000", {frame_err, parity_err, overrun});
        end
        repeat (2) @(negedge clock);
        clr = 1'b0;
        repeat (5) @(negedge clock);
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        checks++;
        if ({valid, count, data} !== {1'b1, 3'd1, 8'hC3}) begin
            errors++; $display("FAIL clr_next got valid=%b count=%0d data=%h want 1/1/c3",
                               valid, count, data);
        end
        pop1();
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_parity();
        test_clr_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
